access_code_entry: RTL and testbench
====================================

Name: access_code_entry

Overview:
Keypad front-end for the employee access system, directly upstream of the 8-bit code comparator.
- Collects up to two decimal digits and forms an 8-bit binary code (tens*10 + units, range 0..99).
- Presents the code to the comparator and samples the comparator's match result.
- Drives the door-grant pulse, counts failed attempts, and enforces a lockout with an alarm pulse toward the security alerting logic.

Parameters:
GRANT_CYCLES, 8, cycles access_grant stays high after a match
DENY_CYCLES, 4, cycles access_deny stays high after a mismatch
MAX_FAILS, 3, consecutive mismatches that trigger lockout (range 1..7)
LOCK_CYCLES, 64, lockout duration in cycles
ENTRY_TIMEOUT, 256, idle cycles in ENTRY before the partial entry is abandoned

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
key_valid  input  1  one-cycle strobe, key_digit valid
key_digit  input  4  decimal digit 0..9; values 10..15 ignored
key_clear  input  1  one-cycle strobe, discard partial entry
key_enter  input  1  one-cycle strobe, submit entry
match_in  input  1  comparator result for code_out (combinational from code_out)
code_out  output  8  submitted code, held until next submission
code_valid  output  1  one-cycle strobe, code_out presented for comparison
access_grant  output  1  door release
access_deny  output  1  rejection indicator
lockout  output  1  keypad locked
alarm_pulse  output  1  one-cycle strobe on lockout entry
fail_cnt  output  3  consecutive failure count

Behaviour:
- Reset (async, any state): state=IDLE; acc=0; digit count=0; timers=0; all outputs 0.
- States: IDLE, ENTRY, CHECK, GRANT, DENY, LOCKOUT.
- IDLE:
  - key_valid with digit<=9: acc=digit, count=1, go to ENTRY.
  - key_enter and key_clear are no-ops.
- ENTRY:
  - key_valid with digit<=9 and count<2: acc=acc*10+digit, count++; the timeout counter restarts.
  - A third digit, or any digit >9, is ignored.
  - key_clear: acc=0, count=0, go to IDLE.
  - key_enter: code_out<=acc, go to CHECK.
  - ENTRY_TIMEOUT cycles with no key strobe: go to IDLE; fail_cnt unchanged.
- Simultaneous strobes: key_clear beats key_enter, and key_enter beats key_valid. The losing strobes are dropped.
- CHECK (exactly 1 cycle):
  - code_valid=1 and match_in is sampled this cycle.
  - Total latency: key_enter at cycle N, then code_valid at N+1, then grant/deny asserted at N+2.
  - match=1: fail_cnt=0, go to GRANT.
  - match=0: fail_cnt++.
    - If the new fail_cnt equals MAX_FAILS: go to LOCKOUT, with alarm_pulse=1 for one cycle on entry.
    - Otherwise go to DENY.
- GRANT: access_grant=1 for GRANT_CYCLES, then IDLE.
- DENY: access_deny=1 for DENY_CYCLES, then IDLE.
- LOCKOUT: lockout=1 for LOCK_CYCLES, then fail_cnt=0 and IDLE.
- All key strobes are ignored in CHECK, GRANT, DENY and LOCKOUT.
- acc and count are cleared on leaving ENTRY.
- code_out holds its value except when updated at submission.
- acc is 7 bits internally (max 99); code_out is zero-extended to 8 bits.
- Reset asserted mid-GRANT or mid-LOCKOUT: outputs drop in the same cycle (async) and fail_cnt returns to 0.

Decomposition:
- Shared package access_pkg:
  - state enum (IDLE, ENTRY, CHECK, GRANT, DENY, LOCKOUT)
  - CODE_W=8 and DIGIT_W=4
  - MAX_DIGIT=9 and DIGITS_PER_CODE=2
- One sub-module, cycle_timer:
  - Ports: load, load value, count-down, done.
  - A single instance serves GRANT, DENY, LOCKOUT and the ENTRY timeout; the FSM reloads it on every state entry and on every accepted key in ENTRY.

Test Plan:
- Digits 3,1 then enter, with the comparator stub matching 8'd31 → code_out=31, code_valid high 1 cycle, access_grant high 8 cycles, fail_cnt=0.
- Digits 2,0 then enter → code_out=20, access_deny high 4 cycles, fail_cnt=1.
- Three consecutive entries of 29 →
  - alarm_pulse once, lockout high 64 cycles.
  - Digit strobes during lockout produce no code_valid.
  - Afterwards fail_cnt=0; then 3,1 grants.
- Input sequence: digit 12 (ignored), then 1, 2, 3, then enter → code_out=12. Then digits 4 and 5 with key_clear and key_enter in the same cycle → IDLE, no code_valid.
- Digit 5 then 256 idle cycles → IDLE, no code_valid, fail_cnt unchanged. Single digit 7 then enter → code_out=7.
- rst pulsed during cycle 3 of GRANT → access_grant=0 immediately, all outputs 0, state IDLE; a following 3,1 entry grants normally.

Source files
------------

// File: rtl/access_pkg.sv
// Shared types and constants for the access-code keypad front-end.
package access_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_GRANT,
    S_DENY,
    S_LOCKOUT
  } state_e;

  localparam int CODE_W          = 8;
  localparam int DIGIT_W         = 4;
  localparam int ACC_W           = 7;
  localparam int MAX_DIGIT       = 9;
  localparam int DIGITS_PER_CODE = 2;

  function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
    return d <= DIGIT_W'(MAX_DIGIT);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Reloadable down-counter shared by every timed phase of the keypad FSM.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         count_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over counting; the counter parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (count_i && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/access_code_entry.sv
// Keypad front-end: builds a two-digit code, submits it to the comparator,
// then drives grant/deny, counts consecutive failures and enforces lockout.
module access_code_entry
  import access_pkg::*;
#(
  parameter int GRANT_CYCLES  = 8,
  parameter int DENY_CYCLES   = 4,
  parameter int MAX_FAILS     = 3,
  parameter int LOCK_CYCLES   = 64,
  parameter int ENTRY_TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic              key_clear,
  input  logic              key_enter,
  input  logic              match_in,
  output logic [CODE_W-1:0] code_out,
  output logic              code_valid,
  output logic              access_grant,
  output logic              access_deny,
  output logic              lockout,
  output logic              alarm_pulse,
  output logic [2:0]        fail_cnt
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int TMAX = max2(max2(GRANT_CYCLES, DENY_CYCLES),
                             max2(LOCK_CYCLES, ENTRY_TIMEOUT));
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] GRANT_LOAD = TW'(GRANT_CYCLES - 1);
  localparam logic [TW-1:0] DENY_LOAD  = TW'(DENY_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0] ENTRY_LOAD = TW'(ENTRY_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [2:0]        fail_q, fail_d;
  logic              alarm_q, alarm_d;

  logic          tmr_load, tmr_count, tmr_done;
  logic [TW-1:0] tmr_val;

  cycle_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .count_i    (tmr_count),
    .done_o     (tmr_done)
  );

  // Strobe priority in ENTRY is clear > enter > digit; any digit strobe
  // counts as keypad activity and restarts the abandonment timeout.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    fail_d    = fail_q;
    alarm_d   = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_count = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (key_valid && digit_ok(key_digit)) begin
          acc_d    = ACC_W'(key_digit);
          cnt_d    = 2'd1;
          state_d  = S_ENTRY;
          tmr_load = 1'b1;
          tmr_val  = ENTRY_LOAD;
        end
      end
      S_ENTRY: begin
        tmr_count = 1'b1;
        if (key_clear) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (key_enter) begin
          code_d  = CODE_W'(acc_q);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_CHECK;
        end else if (key_valid) begin
          tmr_load = 1'b1;
          tmr_val  = ENTRY_LOAD;
          if (digit_ok(key_digit) && (cnt_q < 2'(DIGITS_PER_CODE))) begin
            acc_d = acc_q * ACC_W'(10) + ACC_W'(key_digit);
            cnt_d = cnt_q + 2'd1;
          end
        end else if (tmr_done) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        tmr_load = 1'b1;
        if (match_in) begin
          fail_d  = '0;
          state_d = S_GRANT;
          tmr_val = GRANT_LOAD;
        end else begin
          fail_d = fail_q + 3'd1;
          if (fail_d == 3'(MAX_FAILS)) begin
            alarm_d = 1'b1;
            state_d = S_LOCKOUT;
            tmr_val = LOCK_LOAD;
          end else begin
            state_d = S_DENY;
            tmr_val = DENY_LOAD;
          end
        end
      end
      S_GRANT, S_DENY: begin
        tmr_count = 1'b1;
        if (tmr_done)
          state_d = S_IDLE;
      end
      S_LOCKOUT: begin
        tmr_count = 1'b1;
        if (tmr_done) begin
          fail_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      fail_q  <= '0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      fail_q  <= fail_d;
      alarm_q <= alarm_d;
    end
  end

  assign code_out     = code_q;
  assign code_valid   = (state_q == S_CHECK);
  assign access_grant = (state_q == S_GRANT);
  assign access_deny  = (state_q == S_DENY);
  assign lockout      = (state_q == S_LOCKOUT);
  assign alarm_pulse  = alarm_q;
  assign fail_cnt     = fail_q;

endmodule

// File: tb/tb_access_code_entry.sv
// Self-checking bench for access_code_entry: directed scenarios plus random
// keypad sessions scored against a digit-queue reference model.
module tb_access_code_entry;

  localparam int GRANT_LEN = 8;
  localparam int DENY_LEN  = 4;
  localparam int MAXF      = 3;
  localparam int LOCK_LEN  = 64;
  localparam int TIMEOUT   = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid, key_clear, key_enter;
  logic [3:0] key_digit;
  logic       match_in;
  logic [7:0] code_out;
  logic       code_valid, access_grant, access_deny, lockout, alarm_pulse;
  logic [2:0] fail_cnt;
  logic [7:0] target;

  int compared   = 0;
  int mismatched = 0;

  int q[$];
  int mfail = 0;

  always #5 clk = ~clk;

  // Comparator stub: matches one configurable code.
  assign match_in = (code_out == target);

  access_code_entry #(
    .GRANT_CYCLES(GRANT_LEN), .DENY_CYCLES(DENY_LEN), .MAX_FAILS(MAXF),
    .LOCK_CYCLES(LOCK_LEN), .ENTRY_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_digit(key_digit),
    .key_clear(key_clear), .key_enter(key_enter), .match_in(match_in),
    .code_out(code_out), .code_valid(code_valid), .access_grant(access_grant),
    .access_deny(access_deny), .lockout(lockout), .alarm_pulse(alarm_pulse),
    .fail_cnt(fail_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of strobes, sampled at the next rising edge.
  task automatic applyStimulus(input logic v, input logic [3:0] d, input logic c, input logic e);
    key_valid = v; key_digit = d; key_clear = c; key_enter = e;
    tick();
    key_valid = 1'b0; key_clear = 1'b0; key_enter = 1'b0;
  endtask

  task automatic pressDigit(input int d);
    applyStimulus(1'b1, 4'(d), 1'b0, 1'b0);
    if (d <= 9 && q.size() < 2) q.push_back(d);
  endtask

  function automatic int modelCode();
    return (q.size() == 1) ? q[0] : q[0] * 10 + q[1];
  endfunction

  function automatic logic outcomeSig(input int kind);
    return (kind == 0) ? access_grant : (kind == 1) ? access_deny : lockout;
  endfunction

  // Press enter and follow the whole outcome phase, hammering keys meanwhile.
  task automatic submit();
    int expCode, kind, len, n, bad;
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
    if (q.size() == 0) begin
      checkOutput("idle_enter_no_cv", code_valid, 0);
      return;
    end
    expCode = modelCode();
    q.delete();
    checkOutput("code_valid", code_valid, 1);
    checkOutput("code_out", code_out, expCode);
    if (expCode == int'(target)) begin
      kind = 0; len = GRANT_LEN; mfail = 0;
    end else begin
      mfail++;
      if (mfail == MAXF) begin kind = 2; len = LOCK_LEN; end
      else begin kind = 1; len = DENY_LEN; end
    end
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("code_valid_1cyc", code_valid, 0);
    checkOutput("alarm_pulse", alarm_pulse, kind == 2);
    checkOutput("fail_cnt", fail_cnt, mfail);
    checkOutput("grant_lvl", access_grant, kind == 0);
    checkOutput("deny_lvl", access_deny, kind == 1);
    checkOutput("lock_lvl", lockout, kind == 2);
    n = 0; bad = 0;
    while (outcomeSig(kind) && n < len + 8) begin
      n++;
      applyStimulus(1'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
      if (code_valid || alarm_pulse) bad++;
    end
    checkOutput("outcome_len", n, len);
    checkOutput("quiet_during_outcome", bad, 0);
    if (kind == 2) mfail = 0;
    checkOutput("fail_after", fail_cnt, mfail);
  endtask

  initial begin
    int bad, nd;
    target = 8'd31;
    key_valid = 0; key_digit = 0; key_clear = 0; key_enter = 0;
    rst = 1'b1;
    tick(); tick();
    checkOutput("rst_code_out", code_out, 0);
    checkOutput("rst_flags", {code_valid, access_grant, access_deny, lockout, alarm_pulse}, 0);
    checkOutput("rst_fail_cnt", fail_cnt, 0);
    rst = 1'b0;
    tick();

    $display("[TB] grant on 31, deny on 20");
    pressDigit(3); pressDigit(1); submit();
    pressDigit(2); pressDigit(0); submit();

    $display("[TB] three wrong entries of 29 lock the keypad");
    pressDigit(3); pressDigit(1); submit();
    repeat (3) begin pressDigit(2); pressDigit(9); submit(); end
    pressDigit(3); pressDigit(1); submit();

    $display("[TB] invalid and surplus digits, clear beats enter");
    pressDigit(12); pressDigit(1); pressDigit(2); pressDigit(3); submit();
    pressDigit(4); pressDigit(5);
    applyStimulus(1'b1, 4'd6, 1'b1, 1'b1);
    q.delete();
    bad = 0;
    repeat (4) begin
      if (code_valid) bad++;
      tick();
    end
    checkOutput("clear_beats_enter", bad, 0);
    checkOutput("code_out_held", code_out, 12);

    $display("[TB] entry timeout boundary");
    pressDigit(5);
    bad = 0;
    repeat (TIMEOUT) begin
      tick();
      if (code_valid) bad++;
    end
    checkOutput("timeout_no_cv", bad, 0);
    checkOutput("timeout_fail_cnt", fail_cnt, mfail);
    q.delete();
    pressDigit(7); submit();

    $display("[TB] reset during grant");
    pressDigit(3); pressDigit(1);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
    checkOutput("rg_code_valid", code_valid, 1);
    tick(); tick(); tick();
    checkOutput("rg_grant_before", access_grant, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rg_grant_drop", access_grant, 0);
    checkOutput("rg_all_zero", {code_out, code_valid, access_deny, lockout, alarm_pulse, fail_cnt}, 0);
    #2 rst = 1'b0;
    q.delete(); mfail = 0;
    tick();
    pressDigit(3); pressDigit(1); submit();

    $display("[TB] random sessions");
    for (int i = 0; i < 30; i++) begin
      nd = $urandom_range(0, 3);
      for (int k = 0; k < nd; k++) pressDigit($urandom_range(0, 12));
      if (q.size() > 0 && $urandom_range(0, 1) == 1)
        target = 8'(modelCode());
      else
        target = 8'($urandom_range(0, 99));
      submit();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
